imem_program_loader: RTL and testbench

- Producer side of the instruction stream: assembles 32-bit MIPS instruction words from a byte stream and writes them into instruction memory.
- The fetch/decode path later consumes these words.
- Sits between the byte-serial programming link and the instruction-memory write port; active only while the CPU is held in programming mode.
- Terminates on a sentinel word and reports done, overflow, or timeout.

---
 rtl/imem_program_loader_pkg.sv | 22 ++
 rtl/loader_word_assembler.sv | 46 ++++
 rtl/imem_program_loader.sv | 140 ++++++++++++++
 tb/tb_imem_program_loader.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_program_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
// Contents: instruction word width, default end-of-load sentinel,
// loader state encoding and error-code constants.
package imem_program_loader_pkg;

    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] END_WORD_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } load_state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_OVERFLOW = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

endpackage

// File: rtl/loader_word_assembler.sv
// Big-endian byte-to-word assembler for the program loader.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   clear          - restart assembly at byte 0 (new load)
//   shift_en       - a byte handshake happens this cycle
//   byte_data      - incoming byte
//   byte_idx       - position of the next byte within the word (0..3)
//   word_next      - word as it will look after shifting in byte_data
//   word           - assembled word register (complete in the cycle after the 4th byte)
//   word_complete  - this handshake delivers the 4th byte of a word
module loader_word_assembler
    import imem_program_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               shift_en,
    input  logic [7:0]         byte_data,
    output logic [1:0]         byte_idx,
    output logic [INSTR_W-1:0] word_next,
    output logic [INSTR_W-1:0] word,
    output logic               word_complete
);

    // First byte of a word ends up in [31:24] after three more shifts.
    assign word_next     = {word[INSTR_W-9:0], byte_data};
    assign word_complete = shift_en && (byte_idx == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx <= 2'd0;
        end else if (clear) begin
            byte_idx <= 2'd0;
        end else if (shift_en) begin
            byte_idx <= byte_idx + 2'd1;
        end
    end

    // Pure datapath: only meaningful once four bytes have been shifted in.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            word <= word_next;
        end
    end

endmodule

// File: rtl/imem_program_loader.sv
// Instruction-memory program loader: assembles 32-bit words from a byte
// stream and writes them to consecutive instruction-memory addresses until
// the sentinel word arrives, memory overflows, or a partial word times out.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   start                 - pulse: begin a new load (ignored while loading)
//   byte_valid/byte_data  - byte stream in; byte_ready is the accept side
//   imem_we/addr/wdata    - one-cycle instruction-memory write
//   loading, done, err    - status (done/err sticky until next start)
//   err_code              - 00 none, 01 overflow, 10 timeout
//   word_count            - words written in the current load
module imem_program_loader
    import imem_program_loader_pkg::*;
#(
    parameter int                 ADDR_W         = 14,
    parameter logic [INSTR_W-1:0] END_WORD       = END_WORD_DEFAULT,
    parameter int                 TIMEOUT_CYCLES = 1_000_000
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic               byte_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               loading,
    output logic               done,
    output logic               err,
    output logic [1:0]         err_code,
    output logic [ADDR_W:0]    word_count
);

    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    load_state_t        state, state_n;
    logic [1:0]         err_code_n;
    logic [TO_W-1:0]    to_cnt;
    logic               handshake, begin_load, timed_out, wr_fire;
    logic               word_complete;
    logic [1:0]         byte_idx;
    logic [INSTR_W-1:0] word_next, word;

    // byte_ready is high exactly while in RECV, so handshakes only happen there.
    assign handshake  = byte_valid && byte_ready;
    assign begin_load = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
    assign timed_out  = (state == ST_RECV) && !handshake && (byte_idx != 2'd0)
                        && (to_cnt == TO_LAST);
    // The write is decided on the 4th handshake so imem_we is high during WRITE.
    assign wr_fire    = word_complete && (word_next != END_WORD) && (word_count != DEPTH);

    loader_word_assembler u_asm (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (begin_load),
        .shift_en      (handshake),
        .byte_data     (byte_data),
        .byte_idx      (byte_idx),
        .word_next     (word_next),
        .word          (word),
        .word_complete (word_complete)
    );

    always_comb begin
        state_n    = state;
        err_code_n = err_code;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_n    = ST_RECV;
                    err_code_n = ERR_NONE;
                end
            end
            ST_RECV: begin
                if (word_complete) begin
                    state_n = ST_WRITE;
                end else if (timed_out) begin
                    state_n    = ST_ERR;
                    err_code_n = ERR_TIMEOUT;
                end
            end
            ST_WRITE: begin
                // A non-sentinel word without a write strobe means memory was full.
                if (word == END_WORD) begin
                    state_n = ST_DONE;
                end else if (!imem_we) begin
                    state_n    = ST_ERR;
                    err_code_n = ERR_OVERFLOW;
                end else begin
                    state_n = ST_RECV;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            byte_ready <= 1'b0;
            loading    <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            word_count <= '0;
            to_cnt     <= '0;
        end else begin
            state      <= state_n;
            // Status outputs are registered from the next state so they track state exactly.
            byte_ready <= (state_n == ST_RECV);
            loading    <= (state_n == ST_RECV) || (state_n == ST_WRITE);
            done       <= (state_n == ST_DONE);
            err        <= (state_n == ST_ERR);
            err_code   <= err_code_n;
            imem_we    <= wr_fire;
            if (wr_fire) begin
                imem_addr  <= word_count[ADDR_W-1:0];
                imem_wdata <= word_next;
            end
            if (begin_load) begin
                word_count <= '0;
            end else if (wr_fire) begin
                word_count <= word_count + 1'b1;
            end
            // Only a partially received word is subject to the idle timeout.
            if (begin_load || handshake) begin
                to_cnt <= '0;
            end else if (state == ST_RECV && byte_idx != 2'd0) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_program_loader.sv
// Testbench for imem_program_loader (ADDR_W = 2, TIMEOUT_CYCLES = 16).
module tb_imem_program_loader;

    localparam int ADDR_W  = 2;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'h00;
    logic              byte_ready, imem_we, loading, done, err;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [1:0]        err_code;
    logic [ADDR_W:0]   word_count;

    imem_program_loader #(
        .ADDR_W         (ADDR_W),
        .END_WORD       (32'hFFFF_FFFF),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .loading    (loading),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: a load is a list of 4-byte big-endian words; words go to
    // addresses 0,1,2,... until the sentinel, a word beyond DEPTH, or TIMEOUT idle
    // cycles in the middle of a word.
    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    bit          m_active = 0;
    bit          m_done = 0;
    bit          m_err = 0;
    logic [1:0]  m_code = 2'b00;
    int          m_count = 0;
    int          m_nb = 0;
    int          m_idle = 0;
    logic [31:0] m_word = 32'h0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_active = 0; m_done = 0; m_err = 0; m_code = 2'b00;
            m_count = 0; m_nb = 0; m_idle = 0;
            exp_q.delete();
        end else if (!m_active) begin
            if (start) begin
                m_active = 1; m_done = 0; m_err = 0; m_code = 2'b00;
                m_count = 0; m_nb = 0; m_idle = 0;
            end
        end else if (byte_valid && byte_ready) begin
            m_word = (m_word << 8) | 32'(byte_data);
            m_nb++;
            m_idle = 0;
            if (m_nb == 4) begin
                m_nb = 0;
                if (m_word == 32'hFFFF_FFFF) begin
                    m_done = 1; m_active = 0;
                end else if (m_count == DEPTH) begin
                    m_err = 1; m_code = 2'b01; m_active = 0;
                end else begin
                    exp_q.push_back('{m_count, m_word});
                    m_count++;
                end
            end
        end else if (m_nb != 0) begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
                m_err = 1; m_code = 2'b10; m_active = 0;
            end
        end
    end

    // Per-cycle comparison against the model, plus a log of observed writes.
    int          n_writes = 0;
    int          log_addr[64];
    logic [31:0] log_data[64];
    bit          prev_we = 0;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_we = 0;
        end else begin
            chk("word_count", 64'(word_count), 64'(m_count));
            chk("ready_during_write", 64'(byte_ready && imem_we), 64'd0);
            if (imem_we) begin
                chk("we_single_cycle", {62'd0, prev_we, imem_we}, 64'd1);
                chk("write_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("write_addr_data", {32'(imem_addr), imem_wdata}, {32'(e.addr), e.data});
                end
                if (n_writes < 64) begin
                    log_addr[n_writes] = int'(imem_addr);
                    log_data[n_writes] = imem_wdata;
                end
                n_writes++;
            end
            prev_we = imem_we;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        byte_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int guard = 0;
        forever begin
            @(negedge clk);
            guard++;
            if (guard > 200) begin
                checks++;
                errors++;
                $display("FAIL byte_accept: byte %0h not accepted after %0d cycles", b, guard);
                break;
            end
            if (rnd && $urandom_range(0, 2) == 0) begin
                byte_valid = 1'b0;
            end else begin
                byte_valid = 1'b1;
                byte_data  = b;
                if (byte_ready) break;
            end
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit rnd);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], rnd);
    endtask

    task automatic go_idle();
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic wait_end(input int limit);
        int n = 0;
        while (!(done || err) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("load_finished_in_budget", 64'(done || err), 64'd1);
    endtask

    task automatic chk_restart(input string nm);
        chk(nm, {59'd0, loading, done, err, err_code}, {59'd0, 5'b10000});
        chk({nm, "_count"}, 64'(word_count), 64'd0);
    endtask

    initial begin
        int base;
        // Reset state
        tick(3);
        chk("reset_outputs", {20'd0, byte_ready, imem_we, loading, done, err, err_code,
                              imem_addr, imem_wdata, word_count}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
        chk("idle_not_ready", {62'd0, byte_ready, loading}, 64'd0);

        // Two words plus sentinel, byte_valid held high
        base = n_writes;
        pulse_start();
        chk_restart("start_from_idle");
        send_word(32'h8C01_0004, 0);
        send_word(32'h0022_1820, 0);
        send_word(32'hFFFF_FFFF, 0);
        go_idle();
        wait_end(50);
        chk("A_status", {59'd0, done, err, err_code, loading}, {59'd0, 5'b10000});
        chk("A_word_count", 64'(word_count), 64'd2);
        chk("A_writes", 64'(n_writes - base), 64'd2);
        chk("A_w0", {32'(log_addr[base]), log_data[base]}, {32'd0, 32'h8C01_0004});
        chk("A_w1", {32'(log_addr[base+1]), log_data[base+1]}, {32'd1, 32'h0022_1820});
        chk("A_model_done", 64'(m_done), 64'd1);

        // Same stream with random gaps, restarted from DONE
        base = n_writes;
        pulse_start();
        chk_restart("start_from_done");
        send_word(32'h8C01_0004, 1);
        send_word(32'h0022_1820, 1);
        send_word(32'hFFFF_FFFF, 1);
        go_idle();
        wait_end(80);
        chk("B_done", {62'd0, done, err}, 64'd2);
        chk("B_word_count", 64'(word_count), 64'd2);
        chk("B_writes", 64'(n_writes - base), 64'd2);
        chk("B_w0", {32'(log_addr[base]), log_data[base]}, {32'd0, 32'h8C01_0004});
        chk("B_w1", {32'(log_addr[base+1]), log_data[base+1]}, {32'd1, 32'h0022_1820});

        // Overflow: five non-sentinel words into a 4-word memory
        base = n_writes;
        pulse_start();
        for (int i = 0; i < 5; i++) send_word(32'hA000_0000 + 32'(i), 0);
        go_idle();
        wait_end(50);
        chk("C_status", {59'd0, done, err, err_code}, {59'd0, 4'b0101});
        chk("C_word_count", 64'(word_count), 64'd4);
        chk("C_writes", 64'(n_writes - base), 64'd4);
        for (int i = 0; i < 4; i++)
            chk("C_wr", {32'(log_addr[base+i]), log_data[base+i]}, {32'(i), 32'hA000_0000 + 32'(i)});

        // Timeout: restart from ERR, idle at byte 0, then stall mid-word
        base = n_writes;
        pulse_start();
        chk_restart("start_from_err");
        tick(100);
        chk("D_idle_wait", {61'd0, loading, done, err}, 64'd4);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        go_idle();
        tick(10);
        chk("D_no_early_timeout", 64'(err), 64'd0);
        tick(10);
        chk("D_timeout", {60'd0, err, done, err_code}, {60'd0, 4'b1010});
        chk("D_model_code", 64'(m_code), 64'd2);
        chk("D_writes", 64'(n_writes - base), 64'd0);

        // start during RECV is ignored
        base = n_writes;
        pulse_start();
        send_byte(8'h8C, 0);
        send_byte(8'h01, 0);
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        send_word(32'hFFFF_FFFF, 0);
        go_idle();
        wait_end(50);
        chk("E_done", {62'd0, done, err}, 64'd2);
        chk("E_word_count", 64'(word_count), 64'd1);
        chk("E_w0", {32'(log_addr[base]), log_data[base]}, {32'd0, 32'h8C01_0004});

        // Sentinel as the first word
        base = n_writes;
        pulse_start();
        send_word(32'hFFFF_FFFF, 0);
        go_idle();
        wait_end(50);
        chk("F_done", {62'd0, done, err}, 64'd2);
        chk("F_word_count", 64'(word_count), 64'd0);
        chk("F_writes", 64'(n_writes - base), 64'd0);

        // Exact fill followed by sentinel
        base = n_writes;
        pulse_start();
        for (int i = 0; i < 4; i++) send_word(32'h0BAD_F000 + 32'(i), 0);
        send_word(32'hFFFF_FFFF, 0);
        go_idle();
        wait_end(50);
        chk("G_done", {62'd0, done, err}, 64'd2);
        chk("G_word_count", 64'(word_count), 64'd4);
        chk("G_last", {32'(log_addr[base+3]), log_data[base+3]}, {32'd3, 32'h0BAD_F003});

        // Asynchronous reset during the 3rd byte of word 1
        pulse_start();
        send_word(32'h1111_2222, 0);
        send_byte(8'h00, 0);
        send_byte(8'h22, 0);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = 8'h18;
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {20'd0, byte_ready, imem_we, loading, done, err, err_code,
                                    imem_addr, imem_wdata, word_count}, 64'd0);
        byte_valid = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        base = n_writes;
        pulse_start();
        send_word(32'h0022_1820, 0);
        send_word(32'hFFFF_FFFF, 0);
        go_idle();
        wait_end(50);
        chk("H_done", {62'd0, done, err}, 64'd2);
        chk("H_w0", {32'(log_addr[base]), log_data[base]}, {32'd0, 32'h0022_1820});
        chk("H_word_count", 64'(word_count), 64'd1);

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
